// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one external ALU between two requesters
module alu_arbiter #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  i_req,
  input  logic [7:0]  i_a0,
  input  logic [7:0]  i_b0,
  input  logic [7:0]  i_a1,
  input  logic [7:0]  i_b1,
  input  logic [1:0]  i_ctl0,
  input  logic [1:0]  i_ctl1,
  output logic [1:0]  o_ack,
  output logic [7:0]  o_alu_a,
  output logic [7:0]  o_alu_b,
  output logic [1:0]  o_alu_control,
  input  logic [16:0] i_alu_out,
  output logic        o_rsp_valid,
  output logic        o_rsp_id,
  output logic [16:0] o_rsp_data,
  input  logic        i_rsp_ready,
  output logic        o_busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic ptr_q, ptr_d, id_q, id_d, win;
  logic [7:0] a_q, a_d, b_q, b_d;
  logic [1:0] ctl_q, ctl_d, ack_q, ack_d;
  logic [3:0] cnt_q, cnt_d;
  logic [16:0] data_q, data_d;
  always_comb begin
    win = (i_req == 2'b11) ? ptr_q : i_req[1];
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    a_d = a_q;
    b_d = b_q;
    ctl_d = ctl_q;
    ack_d = 2'b00;
    cnt_d = cnt_q;
    data_d = data_q;
    case (state_q)
      IDLE: if (|i_req) begin
        state_d = EXEC;
        ptr_d = ~win;
        id_d = win;
        a_d = win ? i_a1 : i_a0;
        b_d = win ? i_b1 : i_b0;
        ctl_d = win ? i_ctl1 : i_ctl0;
        ack_d = {win, ~win};
        cnt_d = 4'(EXEC_CYCLES - 1);
      end
      EXEC: if (cnt_q == 4'd0) begin
        data_d = i_alu_out;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      RESP: state_d = i_rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ptr_q <= 1'b0;
      id_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      ctl_q <= '0;
      ack_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      a_q <= a_d;
      b_q <= b_d;
      ctl_q <= ctl_d;
      ack_q <= ack_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
    end
  end
  assign o_ack = ack_q;
  assign o_alu_a = a_q;
  assign o_alu_b = b_q;
  assign o_alu_control = ctl_q;
  assign o_rsp_valid = (state_q == RESP);
  assign o_rsp_id = id_q;
  assign o_rsp_data = data_q;
  assign o_busy = (state_q != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: transaction-level checks of alu_arbiter with EXEC_CYCLES=1 (index 0) and 4 (index 1)
module tb_alu_arbiter;
  logic clk;
  logic rst_n [2];
  logic [1:0] req [2];
  logic [7:0] a0 [2], b0 [2], a1 [2], b1 [2];
  logic [1:0] c0 [2], c1 [2];
  logic rdy [2];
  logic [1:0] ack [2];
  logic [7:0] alu_a [2], alu_b [2];
  logic [1:0] alu_c [2];
  logic [16:0] alu_out [2], data [2];
  logic valid [2], id [2], busy [2];
  int total = 0;
  int bad = 0;
  int ptr [2];

  function automatic logic [16:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [1:0] c);
    case (c)
      2'd0: alu = {9'h0, a ^ b};
      2'd1: alu = {1'b0, a & b, 8'h0} | {8'h0, a ^ b, 1'b0};
      2'd2: alu = {9'h0, a};
      default: alu = {1'b1, b, a};
    endcase
  endfunction

  assign alu_out[0] = alu(alu_a[0], alu_b[0], alu_c[0]);
  assign alu_out[1] = alu(alu_a[1], alu_b[1], alu_c[1]);

  alu_arbiter #(.EXEC_CYCLES(1)) u1 (
    .i_clk(clk), .i_rst_n(rst_n[0]), .i_req(req[0]),
    .i_a0(a0[0]), .i_b0(b0[0]), .i_a1(a1[0]), .i_b1(b1[0]),
    .i_ctl0(c0[0]), .i_ctl1(c1[0]), .o_ack(ack[0]),
    .o_alu_a(alu_a[0]), .o_alu_b(alu_b[0]), .o_alu_control(alu_c[0]),
    .i_alu_out(alu_out[0]), .o_rsp_valid(valid[0]), .o_rsp_id(id[0]),
    .o_rsp_data(data[0]), .i_rsp_ready(rdy[0]), .o_busy(busy[0])
  );

  alu_arbiter #(.EXEC_CYCLES(4)) u4 (
    .i_clk(clk), .i_rst_n(rst_n[1]), .i_req(req[1]),
    .i_a0(a0[1]), .i_b0(b0[1]), .i_a1(a1[1]), .i_b1(b1[1]),
    .i_ctl0(c0[1]), .i_ctl1(c1[1]), .o_ack(ack[1]),
    .o_alu_a(alu_a[1]), .o_alu_b(alu_b[1]), .o_alu_control(alu_c[1]),
    .i_alu_out(alu_out[1]), .o_rsp_valid(valid[1]), .o_rsp_id(id[1]),
    .o_rsp_data(data[1]), .i_rsp_ready(rdy[1]), .o_busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input int d, input string tag);
    chk({tag, ".ack"}, 17'(ack[d]), 17'd0);
    chk({tag, ".valid"}, 17'(valid[d]), 17'd0);
    chk({tag, ".id"}, 17'(id[d]), 17'd0);
    chk({tag, ".data"}, data[d], 17'd0);
    chk({tag, ".alu_a"}, 17'(alu_a[d]), 17'd0);
    chk({tag, ".alu_b"}, 17'(alu_b[d]), 17'd0);
    chk({tag, ".alu_c"}, 17'(alu_c[d]), 17'd0);
    chk({tag, ".busy"}, 17'(busy[d]), 17'd0);
  endtask

  task automatic scramble(input int d);
    a0[d] = 8'($urandom); b0[d] = 8'($urandom); c0[d] = 2'($urandom);
    a1[d] = 8'($urandom); b1[d] = 8'($urandom); c1[d] = 2'($urandom);
  endtask

  // One whole operation starting from IDLE at a falling edge; leaves the DUT back in IDLE.
  task automatic op(input int d, input logic [1:0] r,
                    input logic [7:0] xa0, input logic [7:0] xb0, input logic [1:0] xc0,
                    input logic [7:0] xa1, input logic [7:0] xb1, input logic [1:0] xc1,
                    input int hold, input string tag);
    int e, w, busy_n;
    logic [7:0] wa, wb;
    logic [1:0] wc;
    logic [16:0] ed;
    e = d ? 4 : 1;
    busy_n = 0;
    w = (r == 2'b11) ? ptr[d] : (r == 2'b10 ? 1 : 0);
    wa = w ? xa1 : xa0;
    wb = w ? xb1 : xb0;
    wc = w ? xc1 : xc0;
    ed = alu(wa, wb, wc);
    req[d] = r;
    a0[d] = xa0; b0[d] = xb0; c0[d] = xc0;
    a1[d] = xa1; b1[d] = xb1; c1[d] = xc1;
    @(negedge clk);
    chk({tag, ".ack"}, 17'(ack[d]), 17'(w + 1));
    chk({tag, ".alu_a"}, 17'(alu_a[d]), 17'(wa));
    chk({tag, ".alu_b"}, 17'(alu_b[d]), 17'(wb));
    chk({tag, ".alu_c"}, 17'(alu_c[d]), 17'(wc));
    ptr[d] = 1 - w;
    for (int i = 0; i < e; i++) begin
      if (i > 0) chk({tag, ".ack_exec"}, 17'(ack[d]), 17'd0);
      chk({tag, ".valid_exec"}, 17'(valid[d]), 17'd0);
      busy_n += int'(busy[d]);
      req[d] = 2'($urandom);
      scramble(d);
      rdy[d] = 1'($urandom);
      @(negedge clk);
    end
    chk({tag, ".valid"}, 17'(valid[d]), 17'd1);
    chk({tag, ".data"}, data[d], ed);
    chk({tag, ".id"}, 17'(id[d]), 17'(w));
    chk({tag, ".ack_resp"}, 17'(ack[d]), 17'd0);
    chk({tag, ".alu_a_hold"}, 17'(alu_a[d]), 17'(wa));
    for (int i = 0; i < hold; i++) begin
      busy_n += int'(busy[d]);
      rdy[d] = 1'b0;
      req[d] = 2'($urandom);
      @(negedge clk);
      chk({tag, ".valid_hold"}, 17'(valid[d]), 17'd1);
      chk({tag, ".data_hold"}, data[d], ed);
      chk({tag, ".id_hold"}, 17'(id[d]), 17'(w));
      chk({tag, ".ack_hold"}, 17'(ack[d]), 17'd0);
    end
    busy_n += int'(busy[d]);
    rdy[d] = 1'b1;
    req[d] = 2'b00;
    @(negedge clk);
    rdy[d] = 1'($urandom);
    chk({tag, ".valid_done"}, 17'(valid[d]), 17'd0);
    chk({tag, ".busy_done"}, 17'(busy[d]), 17'd0);
    chk({tag, ".data_keep"}, data[d], ed);
    chk({tag, ".busy_cycles"}, 17'(busy_n), 17'(e + 1 + hold));
  endtask

  initial begin
    int exp_w, last, grants;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0;
      req[d] = 2'b00;
      a0[d] = '0; b0[d] = '0; c0[d] = '0;
      a1[d] = '0; b1[d] = '0; c1[d] = '0;
      rdy[d] = 1'b0;
      ptr[d] = 0;
    end
    repeat (2) @(negedge clk);
    chk_zero(0, "rst0");
    chk_zero(1, "rst1");
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);

    op(0, 2'b01, 8'hF0, 8'h3C, 2'd0, 8'h11, 8'h22, 2'd3, 0, "single");
    op(0, 2'b10, 8'h01, 8'h02, 2'd0, 8'hFF, 8'hFF, 2'd1, 0, "arith_ff");
    op(0, 2'b10, 8'h01, 8'h02, 2'd0, 8'h03, 8'h05, 2'd1, 2, "arith_35");

    // Continuous requests from both sides: each drops its bit for one cycle after its ack.
    req[0] = 2'b11;
    rdy[0] = 1'b1;
    exp_w = ptr[0];
    last = -1;
    grants = 0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      req[0] = 2'b11;
      if (ack[0] != 2'b00) begin
        chk("rr.ack", 17'(ack[0]), 17'(exp_w + 1));
        if (last >= 0) chk("rr.spacing", 17'(c - last), 17'd3);
        last = c;
        exp_w = 1 - exp_w;
        grants++;
        req[0] = 2'b11 & ~ack[0];
      end
    end
    req[0] = 2'b00;
    chk("rr.grants", 17'(grants), 17'd4);
    @(negedge clk);
    chk("rr.idle", 17'(busy[0]), 17'd0);
    ptr[0] = exp_w;
    rdy[0] = 1'b0;

    // Backpressure: a new request waits until the response handshake completes.
    req[0] = 2'b01;
    a0[0] = 8'h12; b0[0] = 8'h34; c0[0] = 2'd3;
    @(negedge clk);
    chk("bp.ack0", 17'(ack[0]), 17'd1);
    req[0] = 2'b10;
    a1[0] = 8'h0F; b1[0] = 8'hF0; c1[0] = 2'd0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp.valid", 17'(valid[0]), 17'd1);
      chk("bp.data", data[0], 17'h13412);
      chk("bp.id", 17'(id[0]), 17'd0);
      chk("bp.no_ack", 17'(ack[0]), 17'd0);
      @(negedge clk);
    end
    rdy[0] = 1'b1;
    @(negedge clk);
    rdy[0] = 1'b0;
    chk("bp.released", 17'(valid[0]), 17'd0);
    chk("bp.ack_wait", 17'(ack[0]), 17'd0);
    @(negedge clk);
    chk("bp.ack1", 17'(ack[0]), 17'd2);
    req[0] = 2'b00;
    rdy[0] = 1'b1;
    @(negedge clk);
    chk("bp.data1", data[0], 17'h000FF);
    chk("bp.id1", 17'(id[0]), 17'd1);
    @(negedge clk);
    ptr[0] = 0;

    op(1, 2'b01, 8'h5A, 8'h00, 2'd2, 8'h77, 8'h66, 2'd0, 1, "exec4");

    // Reset in the middle of EXEC discards the operation and the pointer.
    req[1] = 2'b01;
    a0[1] = 8'hAB; b0[1] = 8'hCD; c0[1] = 2'd3;
    @(negedge clk);
    chk("mid.ack", 17'(ack[1]), 17'd1);
    req[1] = 2'b00;
    @(negedge clk);
    rst_n[1] = 1'b0;
    @(negedge clk);
    rst_n[1] = 1'b1;
    chk_zero(1, "mid.rst");
    ptr[1] = 0;
    rdy[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid.no_rsp", 17'(valid[1]), 17'd0);
    end
    req[1] = 2'b11;
    @(negedge clk);
    chk("mid.grant0", 17'(ack[1]), 17'd1);
    req[1] = 2'b00;
    for (int i = 0; i < 10 && busy[1]; i++) @(negedge clk);
    chk("mid.drain", 17'(busy[1]), 17'd0);
    ptr[1] = 1;

    for (int n = 0; n < 24; n++) begin
      op(n % 2, 2'($urandom_range(1, 3)),
         8'($urandom), 8'($urandom), 2'($urandom),
         8'($urandom), 8'($urandom), 2'($urandom),
         $urandom_range(0, 3), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter EXEC_CYCLES, default 1, meaning ALU settle cycles before result capture; legal range 1..15.
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1, synchronous active-low reset.
REQ-004 SHALL have port i_req, input, 2, request per requester; bit n belongs to requester n.
REQ-005 SHALL have ports i_a0, i_b0 and i_a1, i_b1, input, 8 each, operands of requester 0 and 1.
REQ-006 SHALL have ports i_ctl0 and i_ctl1, input, 2 each, ALU opcode of requester 0 and 1.
REQ-007 SHALL have port o_ack, output, 2, one-cycle grant/accept pulse per requester.
REQ-008 SHALL have ports o_alu_a and o_alu_b, output, 8 each, and o_alu_control, output, 2, driving the shared ALU.
REQ-009 SHALL have port i_alu_out, input, 17, shared ALU result (combinational from o_alu_*).
REQ-010 SHALL have ports o_rsp_valid, output, 1, o_rsp_id, output, 1, and o_rsp_data, output, 17: the response.
REQ-011 SHALL have port i_rsp_ready, input, 1, consumer accepts the response.
REQ-012 SHALL have port o_busy, output, 1, high whenever state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC and RESP; only IDLE samples i_req.
REQ-014 IDLE: if any i_req bit is high at an edge, SHALL select the winner, latch its a/b/ctl into the operand registers, record the winner in o_rsp_id and go to EXEC; otherwise stay IDLE.
REQ-015 Arbitration SHALL be round-robin: a priority pointer names the preferred requester; a lone request wins regardless of the pointer; after a grant, the pointer names the other requester.
REQ-016 o_ack[winner] SHALL be high for exactly the first EXEC cycle; the other o_ack bit stays low; o_ack is never high outside that cycle.
REQ-017 A requester SHALL hold its operands stable while its i_req is high and drop i_req after seeing o_ack; operands changed after the latching edge SHALL NOT affect the operation.
REQ-018 o_alu_a, o_alu_b and o_alu_control SHALL be driven directly from the operand registers in every state, changing only at the latching edge.
REQ-019 EXEC SHALL last exactly EXEC_CYCLES cycles, timed by a 4-bit down-counter; on the edge ending the last EXEC cycle it SHALL capture all 17 bits of i_alu_out into o_rsp_data and go to RESP.
REQ-020 RESP SHALL hold o_rsp_valid high with o_rsp_data and o_rsp_id stable until an edge with i_rsp_ready high; at that edge it SHALL clear o_rsp_valid and go to IDLE.
REQ-021 i_rsp_ready SHALL be ignored outside RESP; i_req SHALL be ignored outside IDLE, so requests arriving mid-operation wait.
REQ-022 With continuous requests and i_rsp_ready held high, throughput SHALL be one operation per EXEC_CYCLES+2 cycles.
REQ-023 o_rsp_data SHALL retain its last captured value after the RESP handshake until the next capture.

Reset
REQ-024 At an edge with i_rst_n low, SHALL go to IDLE and clear o_ack, o_rsp_valid, o_rsp_id, o_rsp_data, the operand registers (hence o_alu_*), the EXEC counter and the pointer (pointer = requester 0).
REQ-025 Reset in EXEC or RESP SHALL discard the in-flight operation with no response; the first edge after release samples i_req as in IDLE.

Verification
REQ-026 Single op, EXEC_CYCLES=1: req0 with a=0xF0, b=0x3C, ctl=0 -> o_ack=01 in the cycle after sampling; o_rsp_valid next cycle with data=0x000CC, id=0.
REQ-027 Arithmetic width: req1 with a=0xFF, b=0xFF, ctl=1 -> data=0x0FF00, id=1; a=3, b=5, ctl=1 -> data=0x0010C.
REQ-028 Round-robin: i_req=11 held, each requester drops req after its ack then re-raises it; ready=1 -> grants alternate 0,1,0,1 with one op every 3 cycles (EXEC_CYCLES=1).
REQ-029 Backpressure: i_rsp_ready low for 5 cycles in RESP -> o_rsp_valid/data/id held stable; new i_req not acked until the cycle after the ready edge.
REQ-030 EXEC_CYCLES=4: ctl=2, a=0x5A -> o_busy high 6 cycles including RESP; data=0x0005A captured after the 4th EXEC cycle.
REQ-031 Reset mid-EXEC: i_rst_n low for 1 cycle during EXEC -> all outputs 0, no response issued, pointer 0; a subsequent i_req=11 grants requester 0.
